// File: rtl/reg_op_scheduler.sv
// Round-robin scheduler that grants one of two requesters access to a
// four-entry register bank and repeats the chosen operation cnt+1 times.
module reg_op_scheduler #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       addr0,
  input  logic [1:0]       addr1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [15:0]      data0,
  input  logic [15:0]      data1,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  input  logic             abort,
  output logic [3:0]       regEnable,
  output logic [1:0]       funSel,
  output logic [15:0]      loadData,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             aborted,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             ptr;
  logic             owner;

  function automatic logic [3:0] addr_onehot(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

  function automatic logic [1:0] req_onehot(input logic k);
    return k ? 2'b10 : 2'b01;
  endfunction

  // Requester 1 wins when it is alone or when both ask and the pointer favours it.
  logic             pick;
  logic [1:0]       sel_addr;
  logic [1:0]       sel_op;
  logic [15:0]      sel_data;
  logic [CNT_W-1:0] sel_cnt;

  always_comb begin
    pick     = req1 & (~req0 | ptr);
    sel_addr = pick ? addr1 : addr0;
    sel_op   = pick ? op1   : op0;
    sel_data = pick ? data1 : data0;
    sel_cnt  = pick ? cnt1  : cnt0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      regEnable <= 4'b0000;
      funSel    <= 2'b00;
      loadData  <= 16'h0000;
      grant     <= 2'b00;
      done      <= 2'b00;
      aborted   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      grant   <= 2'b00;
      done    <= 2'b00;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= pick;
            grant     <= req_onehot(pick);
            regEnable <= addr_onehot(sel_addr);
            funSel    <= sel_op;
            loadData  <= sel_data;
            // Load and clear are single-shot regardless of the requested count.
            remaining <= sel_op[1] ? '0 : sel_cnt;
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (abort) begin
            regEnable <= 4'b0000;
            done      <= req_onehot(owner);
            aborted   <= 1'b1;
            ptr       <= ~owner;
            remaining <= '0;
            state     <= DONE;
          end else if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end else begin
            regEnable <= 4'b0000;
            done      <= req_onehot(owner);
            ptr       <= ~owner;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          regEnable <= 4'b0000;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_op_scheduler.sv
// Directed bench for reg_op_scheduler: each task drives one scenario and
// compares outputs at the falling edge against hand-derived values.
module tb_reg_op_scheduler;

  logic        clock;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  addr0, addr1, op0, op1;
  logic [15:0] data0, data1;
  logic [3:0]  cnt0, cnt1;
  logic        abort;
  logic [3:0]  regEnable;
  logic [1:0]  funSel;
  logic [15:0] loadData;
  logic [1:0]  grant, done;
  logic        aborted, busy;

  int tests;
  int failed;

  reg_op_scheduler #(.CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .op0(op0), .op1(op1),
    .data0(data0), .data1(data1),
    .cnt0(cnt0), .cnt1(cnt1),
    .abort(abort),
    .regEnable(regEnable), .funSel(funSel), .loadData(loadData),
    .grant(grant), .done(done), .aborted(aborted), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; op0 = 0; op1 = 0;
    data0 = 0; data1 = 0; cnt0 = 0; cnt1 = 0; abort = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    req0 = 1;
    abort = 1;
    tick(); tick();
    tests++;
    if ({regEnable, funSel, loadData, grant, done, aborted, busy} !== 27'd0) begin
      failed++;
      $display("FAIL reset_outputs: got en=%b fs=%b ld=%h g=%b d=%b ab=%b busy=%b, want all zero",
               regEnable, funSel, loadData, grant, done, aborted, busy);
    end
    clear_inputs();
    reset = 0;
    tick();
    tests++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle_no_req: got g=%b busy=%b, want 00/0", grant, busy);
    end
  endtask

  task automatic test_increment();
    req0 = 1; addr0 = 2; op0 = 2'b01; cnt0 = 3; data0 = 16'h1111;
    tick();
    tests++;
    if (grant !== 2'b01 || regEnable !== 4'b0100 || funSel !== 2'b01 || busy !== 1'b1) begin
      failed++;
      $display("FAIL inc_accept: got g=%b en=%b fs=%b busy=%b, want 01/0100/01/1",
               grant, regEnable, funSel, busy);
    end
    req0 = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++;
      if (regEnable !== 4'b0100 || funSel !== 2'b01 || grant !== 2'b00 || done !== 2'b00) begin
        failed++;
        $display("FAIL inc_hold_%0d: got en=%b fs=%b g=%b d=%b, want 0100/01/00/00",
                 i, regEnable, funSel, grant, done);
      end
    end
    tick();
    tests++;
    if (regEnable !== 4'b0000 || done !== 2'b01 || busy !== 1'b1) begin
      failed++;
      $display("FAIL inc_done: got en=%b d=%b busy=%b, want 0000/01/1", regEnable, done, busy);
    end
    tick();
    tests++;
    if (done !== 2'b00 || busy !== 1'b0) begin
      failed++;
      $display("FAIL inc_idle: got d=%b busy=%b, want 00/0", done, busy);
    end
  endtask

  task automatic test_load();
    req1 = 1; addr1 = 0; op1 = 2'b10; data1 = 16'hBEEF; cnt1 = 7;
    tick();
    tests++;
    if (grant !== 2'b10 || regEnable !== 4'b0001 || loadData !== 16'hBEEF || funSel !== 2'b10) begin
      failed++;
      $display("FAIL load_accept: got g=%b en=%b ld=%h fs=%b, want 10/0001/beef/10",
               grant, regEnable, loadData, funSel);
    end
    req1 = 0;
    tick();
    tests++;
    if (regEnable !== 4'b0000 || done !== 2'b10) begin
      failed++;
      $display("FAIL load_single: got en=%b d=%b, want 0000/10", regEnable, done);
    end
    tick();
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    pulse_reset();
    req0 = 1; req1 = 1; op0 = 2'b01; op1 = 2'b00; cnt0 = 0; cnt1 = 0;
    addr0 = 1; addr1 = 2;
    tick();
    for (int n = 0; n < 3; n++) begin
      tests++;
      if (grant !== exp_g[n]) begin
        failed++;
        $display("FAIL contention_grant_%0d: got %b, want %b", n, grant, exp_g[n]);
      end
      if (n == 2) begin
        req0 = 0; req1 = 0;
      end
      tick();
      tests++;
      if (done !== exp_g[n]) begin
        failed++;
        $display("FAIL contention_done_%0d: got %b, want %b", n, done, exp_g[n]);
      end
      tick();
      tests++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
        failed++;
        $display("FAIL contention_gap_%0d: got g=%b busy=%b, want 00/0", n, grant, busy);
      end
      tick();
    end
    tests++;
    if (grant !== 2'b00) begin
      failed++;
      $display("FAIL contention_quiet: got %b, want 00", grant);
    end
  endtask

  task automatic test_abort();
    pulse_reset();
    abort = 1;
    tick();
    tests++;
    if (aborted !== 1'b0 || done !== 2'b00) begin
      failed++;
      $display("FAIL abort_idle_ignored: got ab=%b d=%b, want 0/00", aborted, done);
    end
    abort = 0;
    req0 = 1; op0 = 2'b01; cnt0 = 15; addr0 = 1;
    req1 = 1; op1 = 2'b11; cnt1 = 0;  addr1 = 3;
    tick();
    tests++;
    if (grant !== 2'b01 || regEnable !== 4'b0010) begin
      failed++;
      $display("FAIL abort_accept: got g=%b en=%b, want 01/0010", grant, regEnable);
    end
    tick();
    abort = 1;
    tests++;
    if (regEnable !== 4'b0010) begin
      failed++;
      $display("FAIL abort_second_cycle: got en=%b, want 0010", regEnable);
    end
    tick();
    abort = 0; req0 = 0;
    tests++;
    if (regEnable !== 4'b0000 || done !== 2'b01 || aborted !== 1'b1) begin
      failed++;
      $display("FAIL abort_stop: got en=%b d=%b ab=%b, want 0000/01/1", regEnable, done, aborted);
    end
    tick();
    tests++;
    if (aborted !== 1'b0 || done !== 2'b00) begin
      failed++;
      $display("FAIL abort_pulse_len: got ab=%b d=%b, want 0/00", aborted, done);
    end
    tick();
    req1 = 0;
    tests++;
    if (grant !== 2'b10 || regEnable !== 4'b1000 || funSel !== 2'b11) begin
      failed++;
      $display("FAIL abort_next_grant: got g=%b en=%b fs=%b, want 10/1000/11", grant, regEnable, funSel);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    req0 = 1; op0 = 2'b00; cnt0 = 5; addr0 = 3;
    tick();
    req0 = 0;
    tick();
    tests++;
    if (regEnable !== 4'b1000 || busy !== 1'b1) begin
      failed++;
      $display("FAIL rstmid_running: got en=%b busy=%b, want 1000/1", regEnable, busy);
    end
    #2 reset = 1;
    #1;
    tests++;
    if (regEnable !== 4'b0000 || busy !== 1'b0) begin
      failed++;
      $display("FAIL rstmid_async_drop: got en=%b busy=%b, want 0000/0", regEnable, busy);
    end
    req0 = 1; req1 = 1; op0 = 2'b01; op1 = 2'b01; cnt0 = 0; cnt1 = 0;
    @(negedge clock);
    tick();
    tests++;
    if (done !== 2'b00 || grant !== 2'b00) begin
      failed++;
      $display("FAIL rstmid_no_done: got d=%b g=%b, want 00/00", done, grant);
    end
    reset = 0;
    tick();
    tests++;
    if (grant !== 2'b01) begin
      failed++;
      $display("FAIL rstmid_first_grant: got %b, want 01", grant);
    end
    req0 = 0; req1 = 0;
    pulse_reset();
  endtask

  task automatic test_max_count();
    int  high_cycles;
    bit  seen_done;
    req0 = 1; op0 = 2'b00; cnt0 = 15; addr0 = 0; data0 = 16'h1234;
    tick();
    tests++;
    if (regEnable !== 4'b0001 || funSel !== 2'b00 || loadData !== 16'h1234) begin
      failed++;
      $display("FAIL max_accept: got en=%b fs=%b ld=%h, want 0001/00/1234", regEnable, funSel, loadData);
    end
    high_cycles = 1;
    seen_done = 0;
    req0 = 0; data0 = 16'hFFFF; cnt0 = 2; addr0 = 3;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      tick();
      if (done != 2'b00) begin
        seen_done = 1;
      end else begin
        if (regEnable != 4'b0000) high_cycles++;
        tests++;
        if (regEnable !== 4'b0001 || loadData !== 16'h1234) begin
          failed++;
          $display("FAIL max_hold_%0d: got en=%b ld=%h, want 0001/1234", i, regEnable, loadData);
        end
      end
    end
    tests++;
    if (!seen_done || done !== 2'b01) begin
      failed++;
      $display("FAIL max_done: got seen=%0d d=%b, want 1/01", seen_done, done);
    end
    tests++;
    if (high_cycles != 16) begin
      failed++;
      $display("FAIL max_enable_cycles: got %0d, want 16", high_cycles);
    end
    tick(); tick();
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_increment();
    test_load();
    test_contention();
    test_abort();
    test_reset_mid();
    test_max_count();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reg_op_scheduler.md
REG_OP_SCHEDULER -- requirements
Module: reg_op_scheduler

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, setting the width of the repeat-count field.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each, level request from requester 0 and requester 1.
REQ-005 The block SHALL have ports addr0 and addr1, input, 2 bits each, target register index 0..3.
REQ-006 The block SHALL have ports op0 and op1, input, 2 bits each, register operation: 00 decrement, 01 increment, 10 load, 11 clear.
REQ-007 The block SHALL have ports data0 and data1, input, 16 bits each, load value.
REQ-008 The block SHALL have ports cnt0 and cnt1, input, CNT_W bits each, repeat count; the operation executes cnt+1 times.
REQ-009 The block SHALL have port abort, input, 1 bit, synchronous cancel of the running command.
REQ-010 The block SHALL have port regEnable, output, 4 bits, one-hot enable to register bank entries 0..3.
REQ-011 The block SHALL have ports funSel (output, 2 bits) and loadData (output, 16 bits), the operation code and load value driven to the bank.
REQ-012 The block SHALL have ports grant (output, 2 bits), done (output, 2 bits), aborted (output, 1 bit) and busy (output, 1 bit).

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have exactly three states, IDLE, EXEC and DONE; busy SHALL be 1 in EXEC and DONE and 0 in IDLE.
REQ-015 On a rising edge in IDLE with any req high, the block SHALL:
  - choose one requester and latch its addr, op, data and cnt;
  - assert grant[k] for exactly one cycle;
  - drive regEnable[addr] high with funSel=op and loadData=data;
  - enter EXEC.
REQ-016 Arbitration SHALL be round-robin: if only one req is high, that requester wins; if both are high, the requester indicated by the priority pointer wins.
REQ-017 After each command completes or aborts, the priority pointer SHALL point to the other requester.
REQ-018 Command fields SHALL be sampled only on the accept edge; later changes SHALL NOT affect the running command.
REQ-019 For op 10 (load) or 11 (clear), the latched count SHALL be forced to 0 (single cycle).
REQ-020 In EXEC, on each edge where the remaining count is nonzero, the block SHALL decrement it and hold regEnable, funSel and loadData.
REQ-021 In EXEC, on the edge where the remaining count is 0, the block SHALL:
  - clear regEnable;
  - assert done[k] for one cycle;
  - enter DONE.
  regEnable is therefore high for exactly cnt+1 consecutive cycles.
REQ-022 From DONE the block SHALL return to IDLE on the next edge; no request is accepted in DONE, so the earliest new grant comes one cycle after done.
REQ-023 If abort is high on an edge in EXEC, the block SHALL:
  - clear regEnable immediately;
  - assert done[k] and aborted for one cycle;
  - enter DONE;
  - rotate the priority pointer.
REQ-024 abort SHALL be ignored in IDLE and DONE.
REQ-025 A req held high through DONE SHALL be treated as a new request in IDLE.
REQ-026 regEnable SHALL be 0 in IDLE and DONE, and never more than one bit high.
REQ-027 grant and done SHALL each have at most one bit high.
REQ-028 Count arithmetic SHALL be unsigned CNT_W bits; cnt=2^CNT_W-1 SHALL give 2^CNT_W enable cycles with no wrap.

Reset
REQ-029 While reset is high, the block SHALL hold state IDLE, regEnable=0, funSel=00, loadData=0, grant=0, done=0, aborted=0, busy=0, remaining count=0 and priority pointer=requester 0.
REQ-030 Reset asserted mid-EXEC SHALL drop regEnable in the same cycle, asynchronously.
REQ-031 After reset is released, the first accept SHALL occur on the first rising edge with reset low and a req high.

Verification
REQ-032 Single increment: req0=1, addr0=2, op0=01, cnt0=3 -> grant=01 at the accept edge; regEnable=0100 and funSel=01 for 4 cycles; done=01 one cycle later; busy=0 after DONE.
REQ-033 Load count override: req1=1, addr1=0, op1=10, data1=16'hBEEF, cnt1=7 -> regEnable=0001 and loadData=BEEF for exactly 1 cycle; done=10.
REQ-034 Contention: req0=req1=1 held after reset -> grant sequence 01, 10, 01; each new grant follows the previous done by exactly 2 edges.
REQ-035 Abort: req0, cnt0=15, abort pulsed in the 3rd EXEC cycle -> regEnable high for 2 cycles then 0; done=01 and aborted=1 together; the next pending req1 is granted next.
REQ-036 Reset mid-EXEC: reset asserted during a cnt=5 decrement -> regEnable=0 and busy=0 immediately; no done pulse; after release, req1 and req0 both high -> req0 granted first.
REQ-037 Max count: cnt0=15, op0=00 -> regEnable high exactly 16 cycles; field changes on data0, cnt0 and addr0 during EXEC cause no output change.
